conv_layer_sched: RTL and testbench

- Top-level sequencer for the CONV image pipeline.
- Runs the ready/busy host handshake and steps the conv datapath over all 64x64 pixels (layer 0).
- Performs 2x2 max-pool reads/writes (layer 1) and flatten interleave (layer 2).
- Sole owner of the shared result-memory port: csel, crd, cwr, caddr_rd, caddr_wr, cdata_wr.

---
 rtl/conv_layer_sched_if.sv | 46 ++++
 rtl/conv_layer_sched.sv | 203 ++++++++++++++++++++
 tb/tb_conv_layer_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_sched_if.sv
// ---------------------------------------------------------------------------
// conv_layer_sched_if
// Bundle of every signal the CONV layer sequencer exchanges with the host,
// the conv datapath and the shared result memory.
//   master : sequencer side (drives busy, pixel requests, memory strobes)
//   slave  : host / datapath / memory side
// Signals:
//   ready, busy                  host start handshake
//   pix_req, pix_x, pix_y        pixel compute request to the datapath
//   pix_ack, res_valid, res0/1   datapath acceptance and results
//   crd, caddr_rd, cdata_rd      memory read port
//   cwr, caddr_wr, cdata_wr      memory write port
//   csel                         memory bank select
// ---------------------------------------------------------------------------
interface conv_layer_sched_if #(
   parameter int DW = 20,
   parameter int AW = 12,
   parameter int XW = 6
);
   logic          ready;
   logic          busy;
   logic          pix_req;
   logic [XW-1:0] pix_x;
   logic [XW-1:0] pix_y;
   logic          pix_ack;
   logic          res_valid;
   logic [DW-1:0] res0;
   logic [DW-1:0] res1;
   logic          crd;
   logic [AW-1:0] caddr_rd;
   logic [DW-1:0] cdata_rd;
   logic          cwr;
   logic [AW-1:0] caddr_wr;
   logic [DW-1:0] cdata_wr;
   logic [2:0]    csel;

   modport master (
      input  ready, pix_ack, res_valid, res0, res1, cdata_rd,
      output busy, pix_req, pix_x, pix_y, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
   );

   modport slave (
      output ready, pix_ack, res_valid, res0, res1, cdata_rd,
      input  busy, pix_req, pix_x, pix_y, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
   );
endinterface

// File: rtl/conv_layer_sched.sv
// ---------------------------------------------------------------------------
// conv_layer_sched
// Top-level sequencer of the CONV image pipeline:
//   layer 0: requests every pixel from the conv datapath and writes both
//            kernel results to banks L0K0/L0K1,
//   layer 1: 2x2 max-pool of each L0 bank into L1K0/L1K1,
//   layer 2: interleaves L1K0/L1K1 into the flattened L2 bank.
// It is the only master of the shared result-memory port.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   bus        conv_layer_sched_if.master (host, datapath and memory signals)
//   run_cycles busy-cycle counter, present only when the macro
//              CONV_LAYER_SCHED_PERF_EN is defined
// ---------------------------------------------------------------------------
module conv_layer_sched #(
   parameter int DW    = 20,
   parameter int IMG_W = 64,
   parameter int AW    = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   conv_layer_sched_if.master        bus
`ifdef CONV_LAYER_SCHED_PERF_EN
   ,
   output logic [31:0]               run_cycles
`endif
);
   localparam int XW = $clog2(IMG_W);  // pixel coordinate width
   localparam int HW = XW - 1;         // pooled coordinate width
   localparam int QW = 2 * HW;         // pooled index width
   localparam int IW = QW + 1;         // flatten index width (two kernels)

   typedef enum logic [3:0] {
      IDLE, L0_REQ, L0_WAIT, L0_WR0, L0_WR1, L1_RD, L1_WR, L2_RD, L2_WR, DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [AW-1:0] p_reg;
   logic [QW-1:0] q_reg;
   logic          k_reg;
   logic [1:0]    j_reg;
   logic [IW-1:0] i_reg;
   logic [DW-1:0] r0_reg, r1_reg, max_reg, l2_reg;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.ready)     state_next = L0_REQ;
         L0_REQ:  if (bus.pix_ack)   state_next = L0_WAIT;
         L0_WAIT: if (bus.res_valid) state_next = L0_WR0;
         L0_WR0:                     state_next = L0_WR1;
         L0_WR1:  state_next = (&p_reg) ? L1_RD : L0_REQ;
         L1_RD:   if (j_reg == 2'd3) state_next = L1_WR;
         L1_WR:   state_next = (&q_reg && k_reg) ? L2_RD : L1_RD;
         L2_RD:                      state_next = L2_WR;
         L2_WR:   state_next = (&i_reg) ? DONE : L2_RD;
         DONE:                       state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   // counters and data latches
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p_reg   <= '0;
         q_reg   <= '0;
         k_reg   <= 1'b0;
         j_reg   <= '0;
         i_reg   <= '0;
         r0_reg  <= '0;
         r1_reg  <= '0;
         max_reg <= '0;
         l2_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: if (bus.ready) begin
               p_reg <= '0;
               q_reg <= '0;
               k_reg <= 1'b0;
               j_reg <= '0;
               i_reg <= '0;
            end
            L0_WAIT: if (bus.res_valid) begin
               r0_reg <= bus.res0;
               r1_reg <= bus.res1;
            end
            L0_WR1: begin
               if (&p_reg) begin
                  q_reg <= '0;
                  k_reg <= 1'b0;
                  j_reg <= '0;
               end else begin
                  p_reg <= p_reg + 1'b1;
               end
            end
            L1_RD: begin
               // first tap loads, later taps replace only on strictly greater
               if (j_reg == 2'd0 || bus.cdata_rd > max_reg) max_reg <= bus.cdata_rd;
               j_reg <= j_reg + 1'b1;  // wraps to 0 for the next window
            end
            L1_WR: begin
               if (&q_reg) begin
                  q_reg <= '0;
                  if (!k_reg) k_reg <= 1'b1;
                  else        i_reg <= '0;
               end else begin
                  q_reg <= q_reg + 1'b1;
               end
            end
            L2_RD: l2_reg <= bus.cdata_rd;
            L2_WR: i_reg <= i_reg + 1'b1;
            default: ;
         endcase
      end
   end

   // outputs: purely from state, so an async reset clears them at once
   always_comb begin
      bus.busy     = 1'b0;
      bus.pix_req  = 1'b0;
      bus.pix_x    = '0;
      bus.pix_y    = '0;
      bus.crd      = 1'b0;
      bus.caddr_rd = '0;
      bus.cwr      = 1'b0;
      bus.caddr_wr = '0;
      bus.cdata_wr = '0;
      bus.csel     = 3'b000;
      case (state_reg)
         L0_REQ: begin
            bus.busy    = 1'b1;
            bus.pix_req = 1'b1;
            bus.pix_x   = p_reg[XW-1:0];
            bus.pix_y   = p_reg[AW-1:XW];
         end
         L0_WAIT: bus.busy = 1'b1;
         L0_WR0: begin
            bus.busy     = 1'b1;
            bus.cwr      = 1'b1;
            bus.csel     = 3'b001;
            bus.caddr_wr = p_reg;
            bus.cdata_wr = r0_reg;
         end
         L0_WR1: begin
            bus.busy     = 1'b1;
            bus.cwr      = 1'b1;
            bus.csel     = 3'b010;
            bus.caddr_wr = p_reg;
            bus.cdata_wr = r1_reg;
         end
         L1_RD: begin
            bus.busy     = 1'b1;
            bus.crd      = 1'b1;
            bus.csel     = 3'b001 + {2'b00, k_reg};
            // row = 2*qy + j[1], column = 2*qx + j[0]
            bus.caddr_rd = {q_reg[QW-1:HW], j_reg[1], q_reg[HW-1:0], j_reg[0]};
         end
         L1_WR: begin
            bus.busy     = 1'b1;
            bus.cwr      = 1'b1;
            bus.csel     = 3'b011 + {2'b00, k_reg};
            bus.caddr_wr = AW'(q_reg);
            bus.cdata_wr = max_reg;
         end
         L2_RD: begin
            // even i from kernel 0, odd i from kernel 1, same pooled index
            bus.busy     = 1'b1;
            bus.crd      = 1'b1;
            bus.csel     = 3'b011 + {2'b00, i_reg[0]};
            bus.caddr_rd = AW'(i_reg[IW-1:1]);
         end
         L2_WR: begin
            bus.busy     = 1'b1;
            bus.cwr      = 1'b1;
            bus.csel     = 3'b101;
            bus.caddr_wr = AW'(i_reg);
            bus.cdata_wr = l2_reg;
         end
         default: ;
      endcase
   end

`ifdef CONV_LAYER_SCHED_PERF_EN
   // cleared by the start edge, counts busy cycles, holds after DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         run_cycles <= '0;
      else if (state_reg == IDLE && bus.ready)
         run_cycles <= '0;
      else if (state_reg != IDLE && state_reg != DONE)
         run_cycles <= run_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_layer_sched
// Directed bench for conv_layer_sched: a small datapath responder, a banked
// result memory model and hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_conv_layer_sched;
   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   conv_layer_sched_if #(.DW(20), .AW(12), .XW(6)) bus ();

`ifdef CONV_LAYER_SCHED_PERF_EN
   logic [31:0] run_cycles;
   conv_layer_sched #(.DW(20), .IMG_W(64), .AW(12)) dut (
      .clk(clk), .reset(reset), .bus(bus), .run_cycles(run_cycles)
   );
`else
   conv_layer_sched #(.DW(20), .IMG_W(64), .AW(12)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // datapath result patterns (hand-picked values around the pooling windows)
   function automatic logic [19:0] f0(input logic [11:0] p);
      case (p)
         12'd130: f0 = 20'd5;
         12'd131: f0 = 20'd9;
         12'd194: f0 = 20'h80000;
         12'd195: f0 = 20'd3;
         12'd132, 12'd133, 12'd196, 12'd197: f0 = 20'd7;
         default: f0 = (20'(p) * 20'd3) & 20'hFFF;
      endcase
   endfunction

   function automatic logic [19:0] f1(input logic [11:0] p);
      if (p == 12'd4) f1 = 20'hABCDE;
      else            f1 = 20'(p) & 20'hFF;
   endfunction

   // banked result memory: updates on the falling edge
   logic [19:0] mem [1:5][0:4095];
   initial begin
      for (int b = 1; b <= 5; b++)
         for (int a = 0; a < 4096; a++) mem[b][a] = '0;
      bus.cdata_rd = '0;
      forever begin
         @(negedge clk);
         if (bus.cwr && bus.csel >= 3'd1 && bus.csel <= 3'd5) mem[bus.csel][bus.caddr_wr] = bus.cdata_wr;
         if (bus.crd && bus.csel >= 3'd1 && bus.csel <= 3'd5) bus.cdata_rd = mem[bus.csel][bus.caddr_rd];
      end
   end

   // datapath: manual drive, or auto mode that acks in the request cycle
   // and returns results in the following cycle
   logic        dp_auto = 1'b0;
   logic        man_ack = 1'b0, man_valid = 1'b0;
   logic [19:0] man_r0 = '0, man_r1 = '0;
   logic        pending;
   logic [11:0] pend_p;
   initial begin
      pending = 1'b0;
      pend_p = '0;
      bus.pix_ack = 1'b0;
      bus.res_valid = 1'b0;
      bus.res0 = '0;
      bus.res1 = '0;
      forever begin
         @(negedge clk);
         if (!reset) pending = 1'b0;
         if (!dp_auto) begin
            bus.pix_ack   = man_ack;
            bus.res_valid = man_valid;
            bus.res0      = man_r0;
            bus.res1      = man_r1;
         end else begin
            bus.pix_ack   = 1'b0;
            bus.res_valid = 1'b0;
            if (bus.pix_req && !pending) begin
               bus.pix_ack = 1'b1;
               pending = 1'b1;
               pend_p = {bus.pix_y, bus.pix_x};
            end else if (pending && !bus.pix_req) begin
               bus.res_valid = 1'b1;
               bus.res0 = f0(pend_p);
               bus.res1 = f1(pend_p);
               pending = 1'b0;
            end
         end
      end
   end

   initial begin
      bit          found;
      int          collide, l1_rd_cnt, l2_rd_cnt, after;
      bit          last_seen;
      logic [11:0] l1_addr [0:3];
      logic [2:0]  l2_csel;
      logic [11:0] l2_addr;
`ifdef CONV_LAYER_SCHED_PERF_EN
      logic [31:0] perf_snap;
`endif
      reset = 1'b0;
      bus.ready = 1'b0;
      #1;
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_pix_req", bus.pix_req, 0);
      check_eq("rst_crd", bus.crd, 0);
      check_eq("rst_cwr", bus.cwr, 0);
      check_eq("rst_csel", bus.csel, 0);
      check_eq("rst_addrs", {bus.caddr_rd, bus.caddr_wr}, 0);
      check_eq("rst_pix_xy", {bus.pix_x, bus.pix_y}, 0);
      check_eq("rst_cdata_wr", bus.cdata_wr, 0);
      tick; tick;
      reset = 1'b1;
      tick;

      // ---- run A: manual first pixel ----
      bus.ready = 1'b1;
      tick;
      bus.ready = 1'b0;
      check_eq("start_busy", bus.busy, 1);
      check_eq("start_pix_req", bus.pix_req, 1);
      check_eq("start_pix_xy", {bus.pix_x, bus.pix_y}, 0);
      tick; tick;
      check_eq("hold_pix_req", bus.pix_req, 1);
      check_eq("hold_pix_xy", {bus.pix_x, bus.pix_y}, 0);
      // ack cycle with a bogus res_valid that must be ignored
      man_ack = 1'b1; man_valid = 1'b1; man_r0 = 20'hFFFFF; man_r1 = 20'hFFFFF;
      tick;
      man_ack = 1'b0; man_valid = 1'b1; man_r0 = 20'h00123; man_r1 = 20'h00456;
      check_eq("wait_pix_req", bus.pix_req, 0);
      check_eq("wait_cwr", bus.cwr, 0);
      tick;
      man_valid = 1'b0;
      check_eq("wr0_cwr", bus.cwr, 1);
      check_eq("wr0_crd", bus.crd, 0);
      check_eq("wr0_csel", bus.csel, 3'b001);
      check_eq("wr0_addr", bus.caddr_wr, 0);
      check_eq("wr0_data", bus.cdata_wr, 20'h00123);
      tick;
      check_eq("wr1_csel", bus.csel, 3'b010);
      check_eq("wr1_addr", bus.caddr_wr, 0);
      check_eq("wr1_data", bus.cdata_wr, 20'h00456);
      tick;
      check_eq("px1_req", bus.pix_req, 1);
      check_eq("px1_xy", {bus.pix_x, bus.pix_y}, {6'd1, 6'd0});

      dp_auto = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 2000 && !found; n++) begin
         tick;
         if (bus.cwr && bus.csel == 3'b010 && bus.caddr_wr == 12'd63) found = 1'b1;
      end
      check_eq("px63_written", found, 1);
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         tick;
         if (bus.pix_req) found = 1'b1;
      end
      check_eq("px64_req", found, 1);
      check_eq("px64_xy", {bus.pix_x, bus.pix_y}, {6'd0, 6'd1});

      found = 1'b0;
      for (int n = 0; n < 25000 && !found; n++) begin
         tick;
         if (bus.crd) found = 1'b1;
      end
      check_eq("l1_reached", found, 1);
      tick;
      #3 reset = 1'b0;
      #1;
      check_eq("abort_busy", bus.busy, 0);
      check_eq("abort_strobes", {bus.crd, bus.cwr}, 0);
      check_eq("abort_csel", bus.csel, 0);
      check_eq("abort_pix_req", bus.pix_req, 0);
      tick;
      check_eq("abort_hold", {bus.busy, bus.crd, bus.cwr, bus.csel}, 0);
      reset = 1'b1;
      tick;
      bus.ready = 1'b1;
      tick;
      bus.ready = 1'b0;
      check_eq("restart_req", bus.pix_req, 1);
      check_eq("restart_xy", {bus.pix_x, bus.pix_y}, 0);
      reset = 1'b0;
      tick;
      reset = 1'b1;
      tick;

      // ---- run B: full run with auto datapath ----
      collide = 0; l1_rd_cnt = 0; l2_rd_cnt = 0; after = 0; last_seen = 1'b0;
      l2_csel = '0; l2_addr = '0;
      for (int a = 0; a < 4; a++) l1_addr[a] = '0;
      bus.ready = 1'b1;
      tick;
      bus.ready = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 40000 && !found; n++) begin
         if (bus.crd && bus.cwr) collide++;
         if (bus.crd && bus.csel == 3'b001) begin
            if (l1_rd_cnt >= 132 && l1_rd_cnt <= 135) l1_addr[l1_rd_cnt - 132] = bus.caddr_rd;
            l1_rd_cnt++;
         end
         if (bus.crd && (bus.csel == 3'b011 || bus.csel == 3'b100)) begin
            if (l2_rd_cnt == 5) begin
               l2_csel = bus.csel;
               l2_addr = bus.caddr_rd;
            end
            l2_rd_cnt++;
         end
         if (last_seen) after++;
         if (bus.cwr && bus.csel == 3'b101 && bus.caddr_wr == 12'd2047) last_seen = 1'b1;
         if (!bus.busy) found = 1'b1;
         else tick;
      end
      check_eq("run_done", found, 1);
      check_eq("no_rd_wr_overlap", collide, 0);
      check_eq("last_l2_wr_seen", last_seen, 1);
      check_eq("busy_fall_in_2", (after >= 1 && after <= 2), 1);
      check_eq("q33_rd0", l1_addr[0], 12'd130);
      check_eq("q33_rd1", l1_addr[1], 12'd131);
      check_eq("q33_rd2", l1_addr[2], 12'd194);
      check_eq("q33_rd3", l1_addr[3], 12'd195);
      check_eq("l1k0_q33", mem[3][33], 20'h80000);
      check_eq("l1k0_q34_tie", mem[3][34], 20'd7);
      check_eq("l1k0_q0", mem[3][0], 20'd195);
      check_eq("l1k1_q1", mem[4][1], 20'h43);
      check_eq("l1k1_q2", mem[4][2], 20'hABCDE);
      check_eq("l2_i5_csel", l2_csel, 3'b100);
      check_eq("l2_i5_addr", l2_addr, 12'd2);
      check_eq("l2_i5_data", mem[5][5], 20'hABCDE);
      check_eq("l2_i0_data", mem[5][0], 20'd195);
      check_eq("l2_i1_data", mem[5][1], 20'd65);
      check_eq("l2_rd_total", l2_rd_cnt, 2048);
`ifdef CONV_LAYER_SCHED_PERF_EN
      // no busy cycles before the first request; 4 cycles per pixel
      check_eq("run_cycles", run_cycles, 32'd0 + 32'd4096 * 32'd4 + 32'd10240 + 32'd4096);
      perf_snap = 32'd30720;
`endif
      tick; tick; tick;
      check_eq("idle_busy", bus.busy, 0);
      check_eq("idle_pix_req", bus.pix_req, 0);
`ifdef CONV_LAYER_SCHED_PERF_EN
      check_eq("run_cycles_frozen", run_cycles, perf_snap);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
